sprite_mover: RTL
=================

# sprite_mover

Upstream controller for the sprite drawer. Converts player move requests (`move` + `dir`) into a two-phase erase/redraw handshake: first requests a background repaint at the sprite's old position, then a sprite draw at the new one. Owns the sprite position register, clamps it to the playfield, and buffers one move that arrives while a redraw is in flight.

## Interface

Parameters:

- `STEP`, 4: pixels moved per request; equals the sprite edge length.
- `X_INIT`, 0: x position after reset.
- `Y_INIT`, 16: y position after reset.
- `X_MIN`, 0: lowest legal x.
- `Y_MIN`, 16: lowest legal y; rows above it are the HUD.
- `X_MAX`, 316: highest legal x, which is 320−STEP.
- `Y_MAX`, 236: highest legal y, which is 240−STEP.

Ports:

- `clk`  in  1  system clock.
- `resetn`  in  1  reset: resetn, synchronous, active-low; clock clk.
- `move`  in  1  move request level; a rising edge means one move.
- `dir`  in  2  direction, sampled on the `move` edge: 00 up (y−), 01 down (y+), 10 left (x−), 11 right (x+).
- `done_draw`  in  1  drawer finished the current request; held high until the request drops.
- `draw_bg`  out  1  request background repaint of the 4×4 tile at `x_pos`/`y_pos`.
- `draw_char`  out  1  request sprite draw at `x_pos`/`y_pos`.
- `x_pos`  out  9  tile origin x for the active request.
- `y_pos`  out  8  tile origin y for the active request.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation

- Edge detect: `move_d` is registered. `edge = move & ~move_d`. A level held high yields exactly one move.
- Target computation is combinational from the current position and a direction:
  - up: `y < Y_MIN+STEP` gives Y_MIN, else y−STEP.
  - down: `y > Y_MAX−STEP` gives Y_MAX, else y+STEP.
  - left and right follow the same rules on x.
  - Compares use 10-bit zero-extended values so nothing underflows.
- A move is blocked when target equals the current position. A blocked move issues no requests.
- States:
  - BOOT: entered on reset; goes to DRAW unconditionally.
  - IDLE: on `edge`, evaluate `dir`. If blocked, stay in IDLE. Otherwise latch the target into `tgt_x`/`tgt_y` and go to ERASE.
  - ERASE: `draw_bg=1`, outputs show the current position. Go to ERASE_REL on `done_draw=1`.
  - ERASE_REL: no request. On `done_draw=0`, set position to the target and go to DRAW.
  - DRAW: `draw_char=1`, outputs show the current position. Go to DRAW_REL on `done_draw=1`.
  - DRAW_REL: no request. On `done_draw=0`:
    - The effective direction is `dir` if `edge` is high this cycle, else `pend_dir` if `pend_valid`.
    - With an effective direction, evaluate it as in IDLE (go to ERASE, or to IDLE if blocked) and clear `pend_valid`.
    - With none, go to IDLE.
- Pending move: an `edge` in any state other than IDLE sets `pend_valid=1` and `pend_dir=dir`. A later edge overwrites, so the buffer is one deep and the newest move wins.
- `draw_bg` and `draw_char` are Moore outputs decoded from the state register. They are never high together.
- `x_pos`/`y_pos` always equal the position register.

## Timing

- Reset values:
  - state BOOT, `draw_bg=0`, `draw_char=0`, `busy=1`.
  - position (X_INIT,Y_INIT), `pend_valid=0`, `move_d=0`.
- At the first edge with `resetn=1`, the state goes BOOT→DRAW and `draw_char` is high in the following cycle.
- Move latency: an edge seen in IDLE in cycle t gives `draw_bg=1` in cycle t+1.
- Requests are level-held until `done_draw=1` is sampled. They drop the next cycle.
- A new request is never raised until `done_draw=0` has been sampled. This gives a 4-phase handshake with at least one idle cycle between phases.
- The position register updates at the ERASE_REL exit edge. `x_pos`/`y_pos` are stable throughout every request.
- `resetn=0` mid-handshake aborts the handshake. The next cycle is in BOOT with the reset values above.
- `dir` is ignored except in the cycle in which `edge` is high.

## Test plan

- Reset release with `done_draw` answered after 20 cycles → `draw_char=1` at (0,16), then IDLE with `busy=0`.
- From (0,16), pulse `move` with dir=11 → `draw_bg` at (0,16), then `draw_char` at (4,16), with `draw_bg` rising 1 cycle after the edge.
- From (0,16), dir=10 and then dir=00 → both moves blocked: no requests, `busy` stays 0, position unchanged.
- During the ERASE of a right move, issue edges dir=01 then dir=11 → after the first move, exactly one extra move to the right: final position (8,16).
- Hold `move` high for 200 cycles with dir=01 → exactly one move, to (0,20).
- At (316,236): dir=11 and dir=01 blocked. Assert `resetn=0` during DRAW of a move from (312,236) → next cycle BOOT, outputs back to reset values, redraw at (0,16).

Source files
------------

// File: rtl/sprite_mover.sv
// Turns edge-detected move requests into an erase/redraw handshake with the sprite drawer.
// Owns the clamped sprite position and buffers one move that arrives while a redraw is in flight.
module sprite_mover #(
    parameter int unsigned STEP   = 4,
    parameter int unsigned X_INIT = 0,
    parameter int unsigned Y_INIT = 16,
    parameter int unsigned X_MIN  = 0,
    parameter int unsigned Y_MIN  = 16,
    parameter int unsigned X_MAX  = 316,
    parameter int unsigned Y_MAX  = 236
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       move,
    input  logic [1:0] dir,
    input  logic       done_draw,
    output logic       draw_bg,
    output logic       draw_char,
    output logic [8:0] x_pos,
    output logic [7:0] y_pos,
    output logic       busy
);

    typedef enum logic [2:0] {
        StBoot,
        StIdle,
        StErase,
        StEraseRel,
        StDraw,
        StDrawRel
    } state_t;

    localparam logic [9:0] Step10  = 10'(STEP);
    localparam logic [9:0] XMin10  = 10'(X_MIN);
    localparam logic [9:0] YMin10  = 10'(Y_MIN);
    localparam logic [9:0] XMax10  = 10'(X_MAX);
    localparam logic [9:0] YMax10  = 10'(Y_MAX);
    localparam logic [9:0] XLoLim  = 10'(X_MIN + STEP);
    localparam logic [9:0] YLoLim  = 10'(Y_MIN + STEP);
    localparam logic [9:0] XHiLim  = 10'(X_MAX - STEP);
    localparam logic [9:0] YHiLim  = 10'(Y_MAX - STEP);

    state_t     state_q;
    logic [8:0] x_q, tgt_x_q;
    logic [7:0] y_q, tgt_y_q;
    logic       move_d_q;
    logic       pend_valid_q;
    logic [1:0] pend_dir_q;

    logic       move_edge;
    logic       have_dir;
    logic [1:0] eval_dir;
    logic [9:0] x_ext, y_ext, nx_ext, ny_ext;
    logic [8:0] nx;
    logic [7:0] ny;
    logic       blocked;

    assign move_edge = move & ~move_d_q;

    // A fresh edge in DRAW_REL outranks the buffered move.
    always_comb begin
        have_dir = 1'b0;
        eval_dir = dir;
        if (state_q == StIdle) begin
            have_dir = move_edge;
        end else if (state_q == StDrawRel) begin
            if (move_edge) begin
                have_dir = 1'b1;
            end else if (pend_valid_q) begin
                have_dir = 1'b1;
                eval_dir = pend_dir_q;
            end
        end
    end

    always_comb begin
        x_ext  = {1'b0, x_q};
        y_ext  = {2'b00, y_q};
        nx_ext = x_ext;
        ny_ext = y_ext;
        unique case (eval_dir)
            2'b00: ny_ext = (y_ext < YLoLim) ? YMin10 : y_ext - Step10;
            2'b01: ny_ext = (y_ext > YHiLim) ? YMax10 : y_ext + Step10;
            2'b10: nx_ext = (x_ext < XLoLim) ? XMin10 : x_ext - Step10;
            2'b11: nx_ext = (x_ext > XHiLim) ? XMax10 : x_ext + Step10;
            default: ;
        endcase
        nx      = nx_ext[8:0];
        ny      = ny_ext[7:0];
        blocked = (nx == x_q) && (ny == y_q);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= StBoot;
            x_q          <= 9'(X_INIT);
            y_q          <= 8'(Y_INIT);
            tgt_x_q      <= 9'(X_INIT);
            tgt_y_q      <= 8'(Y_INIT);
            move_d_q     <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_dir_q   <= 2'b00;
        end else begin
            move_d_q <= move;
            if (move_edge && state_q != StIdle) begin
                pend_valid_q <= 1'b1;
                pend_dir_q   <= dir;
            end
            case (state_q)
                StBoot: state_q <= StDraw;
                StIdle: begin
                    if (move_edge && !blocked) begin
                        tgt_x_q <= nx;
                        tgt_y_q <= ny;
                        state_q <= StErase;
                    end
                end
                StErase: if (done_draw) state_q <= StEraseRel;
                StEraseRel: begin
                    if (!done_draw) begin
                        x_q     <= tgt_x_q;
                        y_q     <= tgt_y_q;
                        state_q <= StDraw;
                    end
                end
                StDraw: if (done_draw) state_q <= StDrawRel;
                StDrawRel: begin
                    if (!done_draw) begin
                        if (have_dir) begin
                            // Consumes the edge or the buffer; overrides the set above.
                            pend_valid_q <= 1'b0;
                            if (!blocked) begin
                                tgt_x_q <= nx;
                                tgt_y_q <= ny;
                                state_q <= StErase;
                            end else begin
                                state_q <= StIdle;
                            end
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StBoot;
            endcase
        end
    end

    assign draw_bg   = (state_q == StErase);
    assign draw_char = (state_q == StDraw);
    assign busy      = (state_q != StIdle);
    assign x_pos     = x_q;
    assign y_pos     = y_q;

endmodule
